result_write_arbiter: RTL and testbench

RESULT_WRITE_ARBITER -- requirements
Module: result_write_arbiter

---
 rtl/image_params_pkg.sv | 23 ++
 rtl/lane_fifo.sv | 69 ++++++
 rtl/result_write_arbiter.sv | 131 +++++++++++++
 tb/tb_result_write_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/image_params_pkg.sv
// Shared image/lane parameters for the result write path.
// Provides the lane count and coordinate widths, the lane-entry struct
// {row, col, data} that travels through each lane FIFO, and the helper that
// expands a binary result pixel into a 3-bit colour channel.
package image_params_pkg;

    localparam int NUM_PARALLEL_BITS = 2;
    localparam int NUM_PARALLEL      = 1 << NUM_PARALLEL_BITS;
    localparam int WIDTH_BITS        = 8;
    localparam int HEIGHT_BITS       = 8;

    typedef struct packed {
        logic [HEIGHT_BITS-1:0] row;
        logic [WIDTH_BITS-1:0]  col;
        logic                   data;
    } lane_entry_t;

    // A binary pixel is shown as full white or full black on every channel.
    function automatic logic [2:0] pixel_colour(input logic data);
        return {3{data}};
    endfunction

endpackage

// File: rtl/lane_fifo.sv
// Per-lane result FIFO.
// Registered storage of 2^FIFO_DEPTH_BITS lane entries with a combinational
// view of the head entry. A push into a full FIFO is accepted when the same
// edge pops, so a lane that is drained every cycle never loses a write.
// Ports:
//   clock, not_reset      : system clock, asynchronous active-low reset
//   push, push_entry      : write request and entry (ignored when full and not popped)
//   pop                   : remove the head entry (ignored when empty)
//   pop_entry             : current head entry
//   full, empty           : occupancy flags
module lane_fifo
    import image_params_pkg::*;
#(
    parameter int FIFO_DEPTH_BITS = 2
) (
    input  logic        clock,
    input  logic        not_reset,
    input  logic        push,
    input  lane_entry_t push_entry,
    input  logic        pop,
    output lane_entry_t pop_entry,
    output logic        full,
    output logic        empty
);

    localparam int DEPTH = 1 << FIFO_DEPTH_BITS;

    lane_entry_t                mem_r [DEPTH];
    logic [FIFO_DEPTH_BITS-1:0] wr_ptr_r;
    logic [FIFO_DEPTH_BITS-1:0] rd_ptr_r;
    logic [FIFO_DEPTH_BITS:0]   count_r;
    logic                       do_push_s;
    logic                       do_pop_s;

    assign full      = (count_r == (FIFO_DEPTH_BITS+1)'(DEPTH));
    assign empty     = (count_r == '0);
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);
    assign pop_entry = mem_r[rd_ptr_r];

    // Pointer and occupancy bookkeeping; reset empties the FIFO.
    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + FIFO_DEPTH_BITS'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + FIFO_DEPTH_BITS'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + (FIFO_DEPTH_BITS+1)'(1);
                2'b01:   count_r <= count_r - (FIFO_DEPTH_BITS+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clock) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= push_entry;
        end
    end

endmodule

// File: rtl/result_write_arbiter.sv
// Result write arbiter.
// Collects binary result pixels from NUM_PARALLEL producer lanes into
// per-lane FIFOs and serialises them, one pixel per cycle, onto a single
// display-memory write port using round-robin arbitration. Counts emitted
// pixels (saturating at one full frame) and flags frame completion and
// per-lane dropped writes.
// Ports:
//   clock, not_reset            : system clock, asynchronous active-low reset
//   iWren/iCol/iRow/iData       : per-lane result write (flattened, lane 0 in LSBs)
//   oX/oY/oR/oG/oB, oWren       : registered pixel write (oX=row, oY=col)
//   oOverflow                   : sticky per-lane dropped-write flag
//   oPixelCount, oFrameDone     : emitted pixel count and sticky frame-done flag
// The parameters must match the widths in image_params_pkg, which defines
// the lane entry carried by each FIFO.
module result_write_arbiter #(
    parameter int NUM_PARALLEL_BITS = image_params_pkg::NUM_PARALLEL_BITS,
    parameter int WIDTH_BITS        = image_params_pkg::WIDTH_BITS,
    parameter int HEIGHT_BITS       = image_params_pkg::HEIGHT_BITS,
    parameter int FIFO_DEPTH_BITS   = 2,
    localparam int NUM_PARALLEL     = 1 << NUM_PARALLEL_BITS,
    localparam int CNT_W            = WIDTH_BITS + HEIGHT_BITS + 1
) (
    input  logic                                clock,
    input  logic                                not_reset,
    input  logic [NUM_PARALLEL-1:0]             iWren,
    input  logic [NUM_PARALLEL*WIDTH_BITS-1:0]  iCol,
    input  logic [NUM_PARALLEL*HEIGHT_BITS-1:0] iRow,
    input  logic [NUM_PARALLEL-1:0]             iData,
    output logic [7:0]                          oX,
    output logic [7:0]                          oY,
    output logic [2:0]                          oR,
    output logic [2:0]                          oG,
    output logic [2:0]                          oB,
    output logic                                oWren,
    output logic [NUM_PARALLEL-1:0]             oOverflow,
    output logic [CNT_W-1:0]                    oPixelCount,
    output logic                                oFrameDone
);

    localparam logic [CNT_W-1:0] PIX_MAX = CNT_W'(1) << (WIDTH_BITS + HEIGHT_BITS);

    image_params_pkg::lane_entry_t wr_entry_s [NUM_PARALLEL];
    image_params_pkg::lane_entry_t head_s     [NUM_PARALLEL];
    image_params_pkg::lane_entry_t sel_entry_s;
    logic [NUM_PARALLEL-1:0]       empty_s;
    logic [NUM_PARALLEL-1:0]       full_s;
    logic [NUM_PARALLEL-1:0]       pop_s;
    logic [NUM_PARALLEL-1:0]       drop_s;
    logic [NUM_PARALLEL_BITS-1:0]  last_grant_r;
    logic [NUM_PARALLEL_BITS-1:0]  grant_idx_s;
    logic                          grant_valid_s;

    for (genvar i = 0; i < NUM_PARALLEL; i++) begin : g_lane
        assign wr_entry_s[i] = '{row:  iRow[i*HEIGHT_BITS +: HEIGHT_BITS],
                                 col:  iCol[i*WIDTH_BITS +: WIDTH_BITS],
                                 data: iData[i]};

        lane_fifo #(
            .FIFO_DEPTH_BITS (FIFO_DEPTH_BITS)
        ) u_fifo (
            .clock      (clock),
            .not_reset  (not_reset),
            .push       (iWren[i]),
            .push_entry (wr_entry_s[i]),
            .pop        (pop_s[i]),
            .pop_entry  (head_s[i]),
            .full       (full_s[i]),
            .empty      (empty_s[i])
        );
    end

    // Round-robin search starting one past the last granted lane; the
    // wrap-around comes free from the NUM_PARALLEL_BITS-wide addition.
    always_comb begin
        logic [NUM_PARALLEL_BITS-1:0] cand;
        grant_valid_s = 1'b0;
        grant_idx_s   = '0;
        cand          = '0;
        for (int k = 1; k <= NUM_PARALLEL; k++) begin
            cand = last_grant_r + NUM_PARALLEL_BITS'(k);
            if (!grant_valid_s && !empty_s[cand]) begin
                grant_valid_s = 1'b1;
                grant_idx_s   = cand;
            end else begin
                grant_idx_s   = grant_idx_s;
            end
        end
    end

    // Pop strobe for the winner and detection of writes lost to a full lane.
    always_comb begin
        pop_s       = grant_valid_s ? (NUM_PARALLEL'(1) << grant_idx_s) : '0;
        drop_s      = iWren & full_s & ~pop_s;
        sel_entry_s = head_s[grant_idx_s];
    end

    // Registered pixel write port, arbitration state and status flags.
    always_ff @(posedge clock or negedge not_reset) begin
        if (!not_reset) begin
            last_grant_r <= NUM_PARALLEL_BITS'(NUM_PARALLEL - 1);
            oWren        <= 1'b0;
            oX           <= 8'd0;
            oY           <= 8'd0;
            oR           <= 3'd0;
            oG           <= 3'd0;
            oB           <= 3'd0;
            oOverflow    <= '0;
            oPixelCount  <= '0;
            oFrameDone   <= 1'b0;
        end else begin
            oWren     <= grant_valid_s;
            oOverflow <= oOverflow | drop_s;
            if (grant_valid_s) begin
                last_grant_r <= grant_idx_s;
                oX           <= 8'(sel_entry_s.row);
                oY           <= 8'(sel_entry_s.col);
                oR           <= image_params_pkg::pixel_colour(sel_entry_s.data);
                oG           <= image_params_pkg::pixel_colour(sel_entry_s.data);
                oB           <= image_params_pkg::pixel_colour(sel_entry_s.data);
                if (oPixelCount != PIX_MAX) begin
                    oPixelCount <= oPixelCount + CNT_W'(1);
                end
            end
            // Frame done follows one cycle behind the count reaching a full frame.
            if (oPixelCount == PIX_MAX) begin
                oFrameDone <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_result_write_arbiter.sv
// Self-checking bench for result_write_arbiter: directed steps in a single
// initial block, with expected pixels queued in arbitration order as the
// stimulus is driven and compared whenever the DUT raises oWren.
module tb_result_write_arbiter;

    logic        clock;
    logic        not_reset;
    logic [3:0]  iWren;
    logic [31:0] iCol;
    logic [31:0] iRow;
    logic [3:0]  iData;
    logic [7:0]  oX;
    logic [7:0]  oY;
    logic [2:0]  oR;
    logic [2:0]  oG;
    logic [2:0]  oB;
    logic        oWren;
    logic [3:0]  oOverflow;
    logic [16:0] oPixelCount;
    logic        oFrameDone;

    int          n_checks;
    int          n_fail;
    int          wren_cnt;
    int          base_cnt;
    bit          mon_en;
    logic [24:0] exp_q [$];

    result_write_arbiter dut (
        .clock       (clock),
        .not_reset   (not_reset),
        .iWren       (iWren),
        .iCol        (iCol),
        .iRow        (iRow),
        .iData       (iData),
        .oX          (oX),
        .oY          (oY),
        .oR          (oR),
        .oG          (oG),
        .oB          (oB),
        .oWren       (oWren),
        .oOverflow   (oOverflow),
        .oPixelCount (oPixelCount),
        .oFrameDone  (oFrameDone)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [24:0] pix(input logic [7:0] row, input logic [7:0] col, input logic d);
        return {row, col, {3{d}}, {3{d}}, {3{d}}};
    endfunction

    // Compare an emitted pixel against the head of the expected queue.
    task automatic mon();
        logic [24:0] want;
        if (oWren === 1'b1) begin
            wren_cnt++;
            if (mon_en) begin
                n_checks++;
                assert (exp_q.size() != 0) else begin
                    n_fail++;
                    $error("FAIL wren_unexpected: observed oWren=1 expected no pending pixel");
                end
                if (exp_q.size() != 0) begin
                    want = exp_q.pop_front();
                    check("pixel", {7'd0, oX, oY, oR, oG, oB}, {7'd0, want});
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        mon();
    endtask

    task automatic set_lane(input int lane, input logic [7:0] row, input logic [7:0] col, input logic d);
        iWren[lane]          = 1'b1;
        iRow[lane*8 +: 8]    = row;
        iCol[lane*8 +: 8]    = col;
        iData[lane]          = d;
    endtask

    task automatic do_reset();
        iWren     = 4'h0;
        not_reset = 1'b0;
        exp_q.delete();
        tick();
        tick();
        not_reset = 1'b1;
    endtask

    // Cycle index of the r-th accepted write in an 8-cycle accept mask, or -1.
    function automatic int nth_cycle(input logic [7:0] mask, input int r);
        int seen;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            if (mask[c]) begin
                if (seen == r) return c;
                seen++;
            end
        end
        return -1;
    endfunction

    initial begin
        logic [7:0] acc [4];
        int         cyc;
        n_checks  = 0;
        n_fail    = 0;
        wren_cnt  = 0;
        mon_en    = 1'b1;
        iWren     = 4'h0;
        iCol      = 32'h0;
        iRow      = 32'h0;
        iData     = 4'h0;
        not_reset = 1'b0;

        // Reset state
        #3;
        check("rst_wren", {31'd0, oWren}, 32'd0);
        check("rst_xy", {16'd0, oX, oY}, 32'd0);
        check("rst_rgb", {23'd0, oR, oG, oB}, 32'd0);
        check("rst_ovf", {28'd0, oOverflow}, 32'd0);
        check("rst_cnt", {15'd0, oPixelCount}, 32'd0);
        check("rst_done", {31'd0, oFrameDone}, 32'd0);
        tick();
        not_reset = 1'b1;

        // Single write on lane 2: two-edge latency
        set_lane(2, 8'd5, 8'd9, 1'b1);
        exp_q.push_back(pix(8'd5, 8'd9, 1'b1));
        tick();
        check("single_wren_e0", {31'd0, oWren}, 32'd0);
        iWren = 4'h0;
        tick();
        check("single_wren_e1", {31'd0, oWren}, 32'd1);
        check("single_rgb", {23'd0, oR, oG, oB}, 32'h1FF);
        check("single_cnt", {15'd0, oPixelCount}, 32'd1);
        tick();
        check("single_idle", {31'd0, oWren}, 32'd0);
        check("single_hold_x", {24'd0, oX}, 32'd5);

        // All four lanes at once, from reset: lane order 0,1,2,3
        do_reset();
        for (int l = 0; l < 4; l++) begin
            set_lane(l, 8'(8'd10 + l), 8'(8'd20 + l), 1'(l & 1));
            exp_q.push_back(pix(8'(8'd10 + l), 8'(8'd20 + l), 1'(l & 1)));
        end
        tick();
        iWren = 4'h0;
        base_cnt = wren_cnt;
        for (int c = 0; c < 4; c++) tick();
        check("four_emitted", 32'(wren_cnt - base_cnt), 32'd4);
        tick();
        check("four_idle", {31'd0, oWren}, 32'd0);
        check("four_ovf", {28'd0, oOverflow}, 32'd0);
        check("four_cnt", {15'd0, oPixelCount}, 32'd4);
        check("four_queue", 32'(exp_q.size()), 32'd0);

        // Lane 0 every cycle: output every cycle without overflow
        base_cnt = wren_cnt;
        for (int c = 0; c < 10; c++) begin
            set_lane(0, 8'(8'h30 + c), 8'(8'h50 + c), 1'(c & 1));
            exp_q.push_back(pix(8'(8'h30 + c), 8'(8'h50 + c), 1'(c & 1)));
            tick();
            if (c > 0) check("stream_wren", {31'd0, oWren}, 32'd1);
        end
        iWren = 4'h0;
        tick();
        check("stream_last", {31'd0, oWren}, 32'd1);
        check("stream_emitted", 32'(wren_cnt - base_cnt), 32'd10);
        check("stream_ovf", {28'd0, oOverflow}, 32'd0);

        // All lanes every cycle for 8 cycles: overflow on every lane,
        // accepted writes emitted in round-robin rounds with no bubbles
        do_reset();
        acc[0] = 8'h3F;
        acc[1] = 8'h5F;
        acc[2] = 8'h9F;
        acc[3] = 8'h1F;
        for (int r = 0; r < 6; r++) begin
            for (int l = 0; l < 4; l++) begin
                cyc = nth_cycle(acc[l], r);
                if (cyc >= 0) exp_q.push_back(pix(8'(l * 16 + cyc), 8'(8'h40 + cyc), 1'((cyc ^ l) & 1)));
            end
        end
        base_cnt = wren_cnt;
        for (int c = 0; c < 8; c++) begin
            for (int l = 0; l < 4; l++) set_lane(l, 8'(l * 16 + c), 8'(8'h40 + c), 1'((c ^ l) & 1));
            tick();
        end
        iWren = 4'h0;
        for (int c = 0; c < 16; c++) tick();
        check("burst_emitted", 32'(wren_cnt - base_cnt), 32'd23);
        check("burst_queue", 32'(exp_q.size()), 32'd0);
        check("burst_ovf", {28'd0, oOverflow}, 32'hF);
        tick();
        check("burst_idle", {31'd0, oWren}, 32'd0);
        check("burst_cnt", {15'd0, oPixelCount}, 32'd23);

        // Reset with entries queued: outputs clear at once, nothing after release
        do_reset();
        for (int l = 0; l < 4; l++) set_lane(l, 8'(8'h60 + l), 8'(8'h70 + l), 1'b1);
        exp_q.push_back(pix(8'h60, 8'h70, 1'b1));
        tick();
        iWren = 4'h0;
        tick();
        check("mid_wren_before", {31'd0, oWren}, 32'd1);
        #2;
        not_reset = 1'b0;
        #1;
        check("mid_rst_wren", {31'd0, oWren}, 32'd0);
        check("mid_rst_xy", {16'd0, oX, oY}, 32'd0);
        check("mid_rst_rgb", {23'd0, oR, oG, oB}, 32'd0);
        check("mid_rst_cnt", {15'd0, oPixelCount}, 32'd0);
        exp_q.delete();
        tick();
        tick();
        not_reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("mid_post_wren", {31'd0, oWren}, 32'd0);
        end

        // Full frame on lane 0, then one more write after saturation
        mon_en   = 1'b0;
        base_cnt = wren_cnt;
        for (int i = 0; i < 65536; i++) begin
            set_lane(0, 8'(i >> 8), 8'(i), 1'(i & 1));
            tick();
        end
        iWren = 4'h0;
        check("frame_done_early", {31'd0, oFrameDone}, 32'd0);
        tick();
        check("frame_last_wren", {31'd0, oWren}, 32'd1);
        check("frame_cnt", {15'd0, oPixelCount}, 32'd65536);
        check("frame_done_same", {31'd0, oFrameDone}, 32'd0);
        tick();
        check("frame_done", {31'd0, oFrameDone}, 32'd1);
        check("frame_ovf", {28'd0, oOverflow}, 32'd0);
        mon_en = 1'b1;
        set_lane(1, 8'h77, 8'h88, 1'b0);
        exp_q.push_back(pix(8'h77, 8'h88, 1'b0));
        tick();
        iWren = 4'h0;
        tick();
        check("sat_wren", {31'd0, oWren}, 32'd1);
        check("sat_cnt", {15'd0, oPixelCount}, 32'd65536);
        check("sat_done", {31'd0, oFrameDone}, 32'd1);
        check("frame_emitted", 32'(wren_cnt - base_cnt), 32'd65537);
        check("sat_queue", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
